// File: rtl/sprite_dma_pkg.sv
// rtl/sprite_dma_pkg.sv - shared types and constants for the sprite DMA controller
package sprite_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DEFAULT_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] DEFAULT_DEST_ADDR    = 16'h2004;
    localparam int          DMA_LEN              = 256;

    // A CPU bus cycle that requests a transfer: a write to the trigger address.
    function automatic logic is_trigger(input logic        cpu_rw,
                                        input logic [15:0] cpu_addr,
                                        input logic [15:0] trig_addr);
        return !cpu_rw && (cpu_addr == trig_addr);
    endfunction

endpackage

// File: rtl/sprite_dma.sv
// rtl/sprite_dma.sv - bus-mastering page-to-port sprite DMA with CPU stall
module sprite_dma
    import sprite_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = DEFAULT_TRIGGER_ADDR,
    parameter logic [15:0] DEST_ADDR    = DEFAULT_DEST_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cyc_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_odata,
    input  logic        cpu_rw,
    output logic        rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_odata,
    output logic        bus_rw,
    input  logic [7:0]  bus_idata,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] latch_q, latch_d;
    logic       parity_q, parity_d;
    logic       done_q, done_d;

    // Transfer sequencing; everything except the done pulse only moves on cyc_en.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        latch_d  = latch_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        if (cyc_en) begin
            parity_d = ~parity_q;
            case (state_q)
                IDLE: begin
                    if (is_trigger(cpu_rw, cpu_addr, TRIGGER_ADDR)) begin
                        page_d  = cpu_odata;
                        idx_d   = 8'h00;
                        state_d = HALT;
                    end
                end
                HALT: begin
                    // parity after this edge is ~parity_q; an odd next cycle
                    // needs one extra dummy read so READs land on even cycles
                    state_d = parity_q ? READ : ALIGN;
                end
                ALIGN: begin
                    state_d = READ;
                end
                READ: begin
                    latch_d = bus_idata;
                    state_d = WRITE;
                end
                WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and data registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            latch_q  <= 8'h00;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // Bus mux: CPU pass-through when idle, DMA drive (from registers only) otherwise.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_odata = cpu_odata;
        bus_rw    = cpu_rw;
        case (state_q)
            HALT, ALIGN: begin
                bus_addr  = {page_q, 8'h00};
                bus_odata = 8'h00;
                bus_rw    = 1'b1;
            end
            READ: begin
                bus_addr  = {page_q, idx_q};
                bus_odata = 8'h00;
                bus_rw    = 1'b1;
            end
            WRITE: begin
                bus_addr  = DEST_ADDR;
                bus_odata = latch_q;
                bus_rw    = 1'b0;
            end
            default: begin
                bus_addr  = cpu_addr;
                bus_odata = cpu_odata;
                bus_rw    = cpu_rw;
            end
        endcase
    end

    assign rdy  = (state_q == IDLE);
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_sprite_dma.sv
// tb/tb_sprite_dma.sv - self-checking bench for sprite_dma
module tb_sprite_dma;

    logic        clk;
    logic        reset;
    logic        cyc_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_odata;
    logic        cpu_rw;
    logic        rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_odata;
    logic        bus_rw;
    logic [7:0]  bus_idata;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic par_m;
    int   done_clks;
    int   done_bad;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  od;
        logic        rw;
        logic        is_read;
    } op_t;
    op_t exp_q[$];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rw;
        logic [15:0] e_addr;
        logic [7:0]  e_od;
        logic        e_rw;
        logic        e_busy_after;
    } vec_t;
    vec_t vecs [6];

    sprite_dma dut (
        .clk       (clk),
        .reset     (reset),
        .cyc_en    (cyc_en),
        .cpu_addr  (cpu_addr),
        .cpu_odata (cpu_odata),
        .cpu_rw    (cpu_rw),
        .rdy       (rdy),
        .bus_addr  (bus_addr),
        .bus_odata (bus_odata),
        .bus_rw    (bus_rw),
        .bus_idata (bus_idata),
        .busy      (busy),
        .done      (done)
    );

    assign bus_idata = bus_rw ? mem[bus_addr] : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sample_clk();
        if (done) begin
            done_clks++;
            if (!(rdy && !busy)) done_bad++;
        end
    endtask

    task automatic idle_clk();
        cyc_en = 1'b0;
        @(negedge clk);
        sample_clk();
    endtask

    task automatic edge_clk();
        cyc_en = 1'b1;
        @(negedge clk);
        cyc_en = 1'b0;
        par_m  = ~par_m;
        sample_clk();
    endtask

    task automatic run_transfer(input logic [7:0] page, input int want_par, input int abort_byte);
        logic trig_par;
        int   got;
        int   stall;
        int   writes_seen;
        bit   aborted;
        bit   finished;
        logic [7:0] od;
        logic       p;
        if (want_par >= 0 && par_m != want_par[0]) begin
            cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_odata = 8'h00;
            idle_clk();
            edge_clk();
        end
        trig_par = par_m;
        exp_q.delete();
        exp_q.push_back('{addr: {page, 8'h00}, od: 8'h00, rw: 1'b1, is_read: 1'b0});
        if (trig_par)
            exp_q.push_back('{addr: {page, 8'h00}, od: 8'h00, rw: 1'b1, is_read: 1'b0});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{addr: {page, 8'(i)}, od: 8'h00, rw: 1'b1, is_read: 1'b1});
            exp_q.push_back('{addr: 16'h2004, od: mem[{page, 8'(i)}], rw: 1'b0, is_read: 1'b0});
        end

        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_odata = page;
        idle_clk();
        check("trig_passthru", {bus_addr, bus_odata, bus_rw, rdy, busy},
              {16'h4014, page, 1'b0, 1'b1, 1'b0});
        edge_clk();
        check("own_after_trig", {rdy, busy}, {1'b0, 1'b1});

        done_clks = 0; done_bad = 0; got = 0; stall = 0; writes_seen = 0;
        aborted = 0; finished = 0;
        for (int guard = 0; guard < 600; guard++) begin
            cpu_addr  = 16'($urandom);
            cpu_rw    = 1'($urandom);
            cpu_odata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                cpu_addr = 16'h4014; cpu_rw = 1'b0;
            end
            idle_clk();
            if (!busy) begin
                finished = 1;
                break;
            end
            stall++;
            if (got < exp_q.size()) begin
                od = exp_q[got].is_read ? 8'h00 : bus_odata;
                p  = exp_q[got].is_read ? par_m : 1'b0;
                check($sformatf("op%0d", got), {bus_addr, od, bus_rw, rdy, p},
                      {exp_q[got].addr, exp_q[got].od, exp_q[got].rw, 1'b0, 1'b0});
            end else begin
                check("extra_op", got, exp_q.size());
            end
            got++;
            if (abort_byte >= 0 && !bus_rw && writes_seen == abort_byte) begin
                reset  = 1'b1;
                cyc_en = 1'b0;
                @(negedge clk);
                sample_clk();
                reset = 1'b0;
                par_m = 1'b0;
                check("abort_idle", {rdy, busy, done}, {1'b1, 1'b0, 1'b0});
                check("abort_passthru", {bus_addr, bus_odata, bus_rw}, {cpu_addr, cpu_odata, cpu_rw});
                aborted = 1;
                break;
            end
            if (!bus_rw) writes_seen++;
            edge_clk();
        end
        if (aborted) begin
            check("abort_no_done", done_clks, 0);
        end else begin
            if (!finished) check("xfer_timeout", 1, 0);
            check("stall_len", stall, exp_q.size());
            check("done_clks", done_clks, 1);
            check("done_with_idle", done_bad, 0);
            check("rdy_after", {rdy, busy}, {1'b1, 1'b0});
        end
    endtask

    initial begin
        reset = 1'b1; cyc_en = 1'b0; par_m = 1'b0;
        cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_odata = 8'h00;
        done_clks = 0; done_bad = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_ctl", {rdy, busy, done}, {1'b1, 1'b0, 1'b0});
        check("reset_bus", {bus_addr, bus_rw}, {16'h8000, 1'b1});

        vecs[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{16'h4015, 8'h02, 1'b0, 16'h4015, 8'h02, 1'b0, 1'b0};
        vecs[2] = '{16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 8'hA5, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 8'h3C, 1'b1, 16'hFFFF, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{16'h4013, 8'h07, 1'b0, 16'h4013, 8'h07, 1'b0, 1'b0};
        for (int v = 0; v < 6; v++) begin
            cpu_addr = vecs[v].addr; cpu_odata = vecs[v].wdata; cpu_rw = vecs[v].rw;
            idle_clk();
            check($sformatf("vec%0d_bus", v), {bus_addr, bus_odata, bus_rw, rdy, busy},
                  {vecs[v].e_addr, vecs[v].e_od, vecs[v].e_rw, 1'b1, 1'b0});
            edge_clk();
            check($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy_after);
        end

        run_transfer(8'h02, 0, -1);
        run_transfer(8'h02, 1, -1);
        for (int x = 0; x < 256; x++) mem[{8'h07, 8'(x)}] = 8'(x) ^ 8'h5A;
        run_transfer(8'h07, -1, -1);
        run_transfer(8'h03, -1, 8'h80);
        run_transfer(8'h03, -1, -1);
        run_transfer(8'($urandom), -1, -1);
        run_transfer(8'($urandom), -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
